// File: rtl/bb_mpu.sv
// bb_mpu: bit-banged I2C master that brings up an MPU6050 and reads its
// 14-byte accel/temp/gyro burst on request.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active HIGH (1 = reset)
//   mpu_init     1-cycle pulse: run the five-register init write sequence
//   mpu_transfer 1-cycle pulse: run one burst read from register 0x3B
//   scl          I2C clock, driven 0 or 1 (released)
//   sda          I2C data, open-drain (0 or high-Z), sampled as input
//   init_done    sticky: init sequence completed with every byte ACKed
//   data_avalid  1-cycle strobe: data holds a freshly read byte
//   data         last byte read
//   busy_now     a transaction sequence is in progress
module bb_mpu #(
  parameter int unsigned QDIV      = 31,
  parameter logic [6:0]  DEV_ADDR  = 7'h68,
  parameter int unsigned BURST_LEN = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mpu_init,
  input  logic       mpu_transfer,
  output logic       scl,
  inout  logic       sda,
  output logic       init_done,
  output logic       data_avalid,
  output logic [7:0] data,
  output logic       busy_now
);

  typedef enum logic [3:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RSTART, READ_BYTE, SEND_ACK, STOP, GAP
  } state_t;

  localparam logic [15:0] QLAST   = 16'(QDIV - 1);
  localparam logic [7:0]  LAST_RD = 8'(BURST_LEN - 1);

  state_t      state, state_n;
  logic [15:0] div_cnt, div_n;
  logic [1:0]  q, q_n;            // quarter of the current bit/condition
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  step, step_n;      // byte index within the current transaction
  logic [2:0]  txn, txn_n;        // init write transaction index
  logic [7:0]  rd_cnt, rd_n;
  logic        is_read, is_read_n;
  logic        abort, abort_n;
  logic        ack_ok, ack_ok_n;
  logic [7:0]  shreg, shreg_n;
  logic        scl_r, scl_n, sda_r, sda_n;
  logic        init_done_n, avalid_n;
  logic [7:0]  data_n, tx_byte;
  logic        tick, sample, end_q;

  assign tick     = (div_cnt == QLAST);
  assign sample   = tick && (q == 2'd2);  // mid-high of SCL
  assign end_q    = tick && (q == 2'd3);
  assign scl      = scl_r;
  assign sda      = sda_r ? 1'bz : 1'b0;
  assign busy_now = (state != IDLE);

  always_comb begin
    tx_byte = {DEV_ADDR, 1'b0};
    if (is_read) begin
      case (step)
        2'd1:    tx_byte = 8'h3B;
        2'd2:    tx_byte = {DEV_ADDR, 1'b1};
        default: tx_byte = {DEV_ADDR, 1'b0};
      endcase
    end else if (step == 2'd1) begin
      case (txn)
        3'd0:    tx_byte = 8'h6B;
        3'd1:    tx_byte = 8'h19;
        3'd2:    tx_byte = 8'h1A;
        3'd3:    tx_byte = 8'h1B;
        default: tx_byte = 8'h1C;
      endcase
    end else if (step == 2'd2) begin
      case (txn)
        3'd0:    tx_byte = 8'h00;
        3'd1:    tx_byte = 8'h07;
        3'd2:    tx_byte = 8'h06;
        3'd3:    tx_byte = 8'h18;
        default: tx_byte = 8'h01;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    q_n         = q;
    bit_n       = bit_cnt;
    step_n      = step;
    txn_n       = txn;
    rd_n        = rd_cnt;
    is_read_n   = is_read;
    abort_n     = abort;
    ack_ok_n    = ack_ok;
    shreg_n     = shreg;
    init_done_n = init_done;
    avalid_n    = 1'b0;
    data_n      = data;
    scl_n       = scl_r;
    sda_n       = sda_r;

    if (state != IDLE) begin
      div_n = tick ? '0 : div_cnt + 16'd1;
      if (tick) q_n = q + 2'd1;
    end

    // Line levels for the current quarter; SDA is held in quarter 0 so it
    // never moves on the same edge as a falling SCL.
    case (state)
      IDLE, GAP: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end
      START: begin
        scl_n = ~q[1];
        sda_n = (q == 2'd0);
      end
      STOP: begin
        scl_n = q[1];
        if (q != 2'd0) sda_n = (q == 2'd3);
      end
      RSTART: begin
        scl_n = q[1];
        if (q != 2'd0) sda_n = (q != 2'd3);
      end
      SEND_BYTE: begin
        scl_n = q[1];
        if (q == 2'd1) sda_n = tx_byte[3'd7 - bit_cnt];
      end
      SEND_ACK: begin
        scl_n = q[1];
        if (q == 2'd1) sda_n = (rd_cnt == LAST_RD);
      end
      default: begin
        scl_n = q[1];
        if (q == 2'd1) sda_n = 1'b1;
      end
    endcase

    case (state)
      IDLE: begin
        if (mpu_init) begin
          state_n   = START;
          is_read_n = 1'b0;
          txn_n     = '0;
          step_n    = '0;
          abort_n   = 1'b0;
        end else if (mpu_transfer && init_done) begin
          state_n   = START;
          is_read_n = 1'b1;
          step_n    = '0;
          rd_n      = '0;
          abort_n   = 1'b0;
        end
      end
      START, RSTART: if (end_q) state_n = SEND_BYTE;
      SEND_BYTE: if (end_q) begin
        bit_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = GET_ACK;
      end
      GET_ACK: begin
        if (sample) ack_ok_n = ~sda;
        if (end_q) begin
          if (!ack_ok) begin
            state_n = STOP;
            abort_n = 1'b1;
          end else begin
            step_n = step + 2'd1;
            if (is_read)
              state_n = (step == 2'd0) ? SEND_BYTE : (step == 2'd1) ? RSTART : READ_BYTE;
            else
              state_n = (step == 2'd2) ? STOP : SEND_BYTE;
          end
        end
      end
      READ_BYTE: begin
        if (sample) begin
          shreg_n = {shreg[6:0], sda};
          if (bit_cnt == 3'd7) begin
            data_n   = {shreg[6:0], sda};
            avalid_n = 1'b1;
          end
        end
        if (end_q) begin
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = SEND_ACK;
        end
      end
      SEND_ACK: if (end_q) begin
        if (rd_cnt == LAST_RD) begin
          state_n = STOP;
        end else begin
          rd_n    = rd_cnt + 8'd1;
          state_n = READ_BYTE;
        end
      end
      STOP: if (end_q) state_n = GAP;
      GAP: if (end_q) begin
        if (!is_read && !abort && txn != 3'd4) begin
          txn_n   = txn + 3'd1;
          step_n  = '0;
          state_n = START;
        end else begin
          state_n = IDLE;
          if (!is_read && !abort) init_done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      q           <= '0;
      bit_cnt     <= '0;
      step        <= '0;
      txn         <= '0;
      rd_cnt      <= '0;
      is_read     <= 1'b0;
      abort       <= 1'b0;
      ack_ok      <= 1'b0;
      shreg       <= '0;
      scl_r       <= 1'b1;
      sda_r       <= 1'b1;
      init_done   <= 1'b0;
      data_avalid <= 1'b0;
      data        <= '0;
    end else begin
      state       <= state_n;
      div_cnt     <= div_n;
      q           <= q_n;
      bit_cnt     <= bit_n;
      step        <= step_n;
      txn         <= txn_n;
      rd_cnt      <= rd_n;
      is_read     <= is_read_n;
      abort       <= abort_n;
      ack_ok      <= ack_ok_n;
      shreg       <= shreg_n;
      scl_r       <= scl_n;
      sda_r       <= sda_n;
      init_done   <= init_done_n;
      data_avalid <= avalid_n;
      data        <= data_n;
    end
  end

endmodule

// File: tb/tb_bb_mpu.sv
// Self-checking bench for bb_mpu with a behavioural MPU6050 slave that
// decodes the bus into tokens: START/Sr, STOP, and {ack_bit, byte} per slot.
module tb_bb_mpu;

  localparam int QD = 8;
  localparam int T_START = 'h400;
  localparam int T_STOP  = 'h800;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mpu_init = 1'b0;
  logic       mpu_transfer = 1'b0;
  logic       scl;
  wire        sda;
  logic       init_done, data_avalid, busy_now;
  logic [7:0] data;

  bb_mpu #(.QDIV(QD), .DEV_ADDR(7'h68), .BURST_LEN(14)) dut (
    .clk(clk), .rst_n(rst_n), .mpu_init(mpu_init), .mpu_transfer(mpu_transfer),
    .scl(scl), .sda(sda), .init_done(init_done), .data_avalid(data_avalid),
    .data(data), .busy_now(busy_now)
  );

  always #5 clk = ~clk;

  // Slave model
  logic       slv_low = 1'b0;
  bit         slv_en = 1'b1;
  assign sda = (slv_low && slv_en) ? 1'b0 : 1'bz;
  pullup (sda);

  int         tokens[$];
  int         strobes[$];
  int         exp_tok[$];
  logic       scl_q = 1'b1, sda_q = 1'b1;
  int         bitn = 0;
  logic [7:0] sh = '0, rd_val = '0;
  logic       ackbit = 1'b1;
  bit         active = 0, first = 0, sending = 0, rd_mode = 0, acked = 0;

  always @(scl or sda) begin
    if (scl !== scl_q) begin
      if (active && scl === 1'b1) begin
        if (bitn < 8) sh = {sh[6:0], sda === 1'b1};
        else ackbit = (sda === 1'b1);
        bitn++;
      end else if (active) begin
        if (bitn == 8) begin
          if (sending) slv_low = 1'b0;
          else begin
            if (first) begin
              acked   = slv_en && (sh[7:1] == 7'h68);
              rd_mode = sh[0];
              first   = 0;
              if (sh[0]) rd_val = '0;
            end else acked = slv_en;
            slv_low = acked;
          end
        end else if (bitn == 9) begin
          bitn = 0;
          tokens.push_back({23'd0, ackbit, sh});
          if (sending) begin
            if (!ackbit) begin
              rd_val++;
              slv_low = ~rd_val[7];
            end else begin
              sending = 0;
              slv_low = 1'b0;
            end
          end else begin
            slv_low = 1'b0;
            if (rd_mode && acked) begin
              sending = 1;
              slv_low = ~rd_val[7];
            end
          end
        end else if (sending && bitn < 8) slv_low = ~rd_val[7 - bitn];
      end
    end else if (sda !== sda_q && scl === 1'b1) begin
      if (sda === 1'b0) begin
        tokens.push_back(T_START);
        active = 1; bitn = 0; first = 1; sending = 0; rd_mode = 0; slv_low = 1'b0;
      end else if (active) begin
        tokens.push_back(T_STOP);
        active = 0; slv_low = 1'b0;
      end
    end
    scl_q = scl;
    sda_q = sda;
  end

  always @(negedge clk) if (data_avalid) strobes.push_back(int'(data));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int init_reg[5] = '{'h6B, 'h19, 'h1A, 'h1B, 'h1C};
  int init_val[5] = '{'h00, 'h07, 'h06, 'h18, 'h01};

  // kind: 0 no traffic, 1 init NACKed on address, 2 full init, 3 burst read
  task automatic build_exp(input int kind);
    exp_tok.delete();
    if (kind == 1) begin
      exp_tok.push_back(T_START); exp_tok.push_back('h1D0); exp_tok.push_back(T_STOP);
    end else if (kind == 2) begin
      for (int t = 0; t < 5; t++) begin
        exp_tok.push_back(T_START); exp_tok.push_back('h0D0);
        exp_tok.push_back(init_reg[t]); exp_tok.push_back(init_val[t]);
        exp_tok.push_back(T_STOP);
      end
    end else if (kind == 3) begin
      exp_tok.push_back(T_START); exp_tok.push_back('h0D0); exp_tok.push_back('h03B);
      exp_tok.push_back(T_START); exp_tok.push_back('h0D1);
      for (int i = 0; i < 14; i++) exp_tok.push_back((i == 13) ? ('h100 | i) : i);
      exp_tok.push_back(T_STOP);
    end
  endtask

  typedef struct {
    string name;
    bit    init_p, xfer_p, slave_on, poke_init;
    bit    exp_busy;
    int    kind;
    bit    exp_done_during, exp_done;
    int    exp_strobes;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  int   cyc, n_str, prev_scl, fall_cnt, per;
  bit   done_ok;

  initial begin
    vecs[0] = '{"xfer_pre_init", 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{"init_nack",     1, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[2] = '{"init",          1, 0, 1, 0, 1, 2, 0, 1, 0};
    vecs[3] = '{"read_poke",     0, 1, 1, 1, 1, 3, 1, 1, 14};
    vecs[4] = '{"reinit",        1, 0, 1, 0, 1, 2, 1, 1, 0};
    vecs[5] = '{"both_pulses",   1, 1, 1, 0, 1, 2, 1, 1, 0};

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl", int'(scl), 1);
    check("rst_sda", int'(sda === 1'b1), 1);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy_now), 0);
    check("rst_data", int'(data), 0);
    check("rst_avalid", int'(data_avalid), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      slv_en = v.slave_on;
      build_exp(v.kind);
      tokens.delete();
      strobes.delete();
      @(negedge clk);
      mpu_init = v.init_p;
      mpu_transfer = v.xfer_p;
      @(negedge clk);
      mpu_init = 1'b0;
      mpu_transfer = 1'b0;
      check({v.name, "_busy_rise"}, int'(busy_now), int'(v.exp_busy));
      cyc = 0;
      done_ok = 1;
      while (busy_now && cyc < 20000) begin
        if (init_done !== v.exp_done_during) done_ok = 0;
        @(negedge clk);
        cyc++;
        mpu_init = v.poke_init && (cyc == 300);
      end
      mpu_init = 1'b0;
      if (v.exp_busy) begin
        check({v.name, "_finish_in_time"}, int'(cyc < 20000), 1);
        check({v.name, "_init_done_while_busy"}, int'(done_ok), 1);
      end
      check({v.name, "_init_done_at_fall"}, int'(init_done), int'(v.exp_done));
      repeat (50) @(negedge clk);
      check({v.name, "_busy_after"}, int'(busy_now), 0);
      check({v.name, "_token_count"}, tokens.size(), exp_tok.size());
      for (int i = 0; i < exp_tok.size(); i++)
        check($sformatf("%s_token%0d", v.name, i), (i < tokens.size()) ? tokens[i] : -1, exp_tok[i]);
      check({v.name, "_strobe_count"}, strobes.size(), v.exp_strobes);
      for (int i = 0; i < v.exp_strobes; i++)
        check($sformatf("%s_data%0d", v.name, i), (i < strobes.size()) ? strobes[i] : -1, i);
    end

    // Read interrupted by reset; also measures one SCL period mid-byte.
    slv_en = 1'b1;
    strobes.delete();
    @(negedge clk);
    mpu_transfer = 1'b1;
    @(negedge clk);
    mpu_transfer = 1'b0;
    cyc = 0;
    while (strobes.size() < 2 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_read_strobes_seen", int'(strobes.size() >= 2), 1);
    prev_scl = int'(scl);
    fall_cnt = 0;
    per = 0;
    cyc = 0;
    while (fall_cnt < 2 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (fall_cnt == 1) per++;
      if (prev_scl == 1 && scl == 1'b0) fall_cnt++;
      prev_scl = int'(scl);
    end
    check("scl_period", per, 4 * QD);
    repeat (QD * 5) @(negedge clk);
    slv_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_str = strobes.size();
    check("mid_rst_scl", int'(scl), 1);
    check("mid_rst_sda", int'(sda === 1'b1), 1);
    check("mid_rst_busy", int'(busy_now), 0);
    check("mid_rst_avalid", int'(data_avalid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (400) @(negedge clk);
    check("post_rst_no_strobes", strobes.size(), n_str);
    check("post_rst_busy", int'(busy_now), 0);
    check("post_rst_init_done", int'(init_done), 0);
    check("post_rst_scl", int'(scl), 1);
    check("post_rst_data", int'(data), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
